llr_frame_loader: RTL and testbench

Upstream front-end and sequencer for the 6-bit LDPC `decoder`. Accepts a stream of signed channel samples and scales each one with saturation into a WIDTH-bit LLR. Packs N LLRs into the decoder's parallel LLR bus, pulses the decoder reset to load them, and waits for the decoder's `done`. It then returns the hard-decision codeword, the decode status and the iteration count on a valid/ready output.

---
 rtl/ldpc_pkg.sv | 19 +
 rtl/llr_frame_loader_sat.sv | 32 +++
 rtl/llr_frame_loader.sv | 175 +++++++++++++++++
 tb/tb_llr_frame_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared LDPC definitions: decode status codes, loader FSM states and default sizes.
package ldpc_pkg;

  localparam int unsigned LDPC_WIDTH = 20;
  localparam int unsigned LDPC_N     = 6;

  localparam logic [1:0] ST_CONV  = 2'b10;
  localparam logic [1:0] ST_MAXIT = 2'b01;
  localparam logic [1:0] ST_ERR   = 2'b11;

  typedef enum logic [2:0] {
    StLoad,
    StDrop,
    StStart,
    StRun,
    StOut
  } loader_state_e;

endpackage

// File: rtl/llr_frame_loader_sat.sv
// Sign-extend a channel sample, shift it left and clamp it symmetrically to a WIDTH-bit LLR.
module llr_sat_scale #(
  parameter int unsigned WIDTH     = 20,
  parameter int unsigned SAMPLE_W  = 8,
  parameter int unsigned LLR_SHIFT = 4
) (
  input  logic signed [SAMPLE_W-1:0] i_sample,
  output logic signed [WIDTH-1:0]    o_llr
);

  // Wide enough that the shift itself can never wrap before the clamp sees it.
  localparam int unsigned CALC_W = (SAMPLE_W + LLR_SHIFT > WIDTH + 1) ?
                                   SAMPLE_W + LLR_SHIFT : WIDTH + 1;
  localparam logic signed [CALC_W-1:0] MAX_POS = CALC_W'((64'd1 << (WIDTH - 1)) - 64'd1);
  localparam logic signed [CALC_W-1:0] MIN_NEG = -MAX_POS;

  logic signed [CALC_W-1:0] w_ext;
  logic signed [CALC_W-1:0] w_shift;

  assign w_ext   = {{(CALC_W - SAMPLE_W){i_sample[SAMPLE_W-1]}}, i_sample};
  assign w_shift = w_ext <<< LLR_SHIFT;

  always_comb begin
    o_llr = w_shift[WIDTH-1:0];
    if (w_shift > MAX_POS) begin
      o_llr = MAX_POS[WIDTH-1:0];
    end else if (w_shift < MIN_NEG) begin
      o_llr = MIN_NEG[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/llr_frame_loader.sv
// Frame sequencer: loads N scaled LLRs, pulses the decoder reset, waits for done and
// returns the hard decision, status and iteration count on a valid/ready port.
module llr_frame_loader
  import ldpc_pkg::*;
#(
  parameter int unsigned WIDTH       = LDPC_WIDTH,
  parameter int unsigned N           = LDPC_N,
  parameter int unsigned SAMPLE_W    = 8,
  parameter int unsigned LLR_SHIFT   = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [SAMPLE_W-1:0]   s_data,
  input  logic                  s_last,
  input  logic [WIDTH-1:0]      cfg_max_iter,
  output logic [N*WIDTH-1:0]    dec_llrs,
  output logic [WIDTH-1:0]      dec_max_iter,
  output logic                  dec_rst,
  input  logic [1:0]            dec_done,
  input  logic [N-1:0]          dec_result,
  input  logic [WIDTH-1:0]      dec_iter,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [N-1:0]          m_cw,
  output logic [1:0]            m_status,
  output logic [WIDTH-1:0]      m_iter
);

  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  loader_state_e     r_state, w_state;
  logic [KW-1:0]     r_k, w_k;
  logic              r_start, w_start;
  logic [TW-1:0]     r_tmo, w_tmo;
  logic [WIDTH-1:0]  r_llrs [N];
  logic [WIDTH-1:0]  r_max_iter;
  logic [N-1:0]      r_cw, w_cw;
  logic [1:0]        r_status, w_status;
  logic [WIDTH-1:0]  r_iter, w_iter;
  logic              w_beat;
  logic              w_load_beat;
  logic [WIDTH-1:0]  w_llr;

  llr_sat_scale #(
    .WIDTH    (WIDTH),
    .SAMPLE_W (SAMPLE_W),
    .LLR_SHIFT(LLR_SHIFT)
  ) u_scale (
    .i_sample(s_data),
    .o_llr   (w_llr)
  );

  assign s_ready      = ~rst & ((r_state == StLoad) | (r_state == StDrop));
  assign w_beat       = s_valid & s_ready;
  assign w_load_beat  = w_beat & (r_state == StLoad);
  assign dec_rst      = rst | (r_state == StStart);
  assign dec_max_iter = r_max_iter;
  assign m_valid      = (r_state == StOut);
  assign m_cw         = r_cw;
  assign m_status     = r_status;
  assign m_iter       = r_iter;

  for (genvar g = 0; g < N; g++) begin : g_llr_bus
    assign dec_llrs[g*WIDTH +: WIDTH] = r_llrs[g];
  end

  always_comb begin
    w_state  = r_state;
    w_k      = r_k;
    w_start  = r_start;
    w_tmo    = r_tmo;
    w_cw     = r_cw;
    w_status = r_status;
    w_iter   = r_iter;
    unique case (r_state)
      StLoad: begin
        if (w_beat) begin
          if (r_k == K_LAST) begin
            w_k     = '0;
            w_start = 1'b0;
            w_state = s_last ? StStart : StDrop;
          end else if (s_last) begin
            w_k      = '0;
            w_state  = StOut;
            w_cw     = '0;
            w_status = ST_ERR;
            w_iter   = '0;
          end else begin
            w_k = r_k + 1'b1;
          end
        end
      end
      StDrop: begin
        if (w_beat && s_last) begin
          w_state  = StOut;
          w_cw     = '0;
          w_status = ST_ERR;
          w_iter   = '0;
        end
      end
      StStart: begin
        // Two-cycle decoder reset pulse; r_start marks the second cycle.
        if (r_start) begin
          w_start = 1'b0;
          w_tmo   = '0;
          w_state = StRun;
        end else begin
          w_start = 1'b1;
        end
      end
      StRun: begin
        w_tmo = r_tmo + 1'b1;
        // r_tmo == 0 is the first RUN cycle, where a stale done is ignored.
        if ((r_tmo != '0) && (dec_done != 2'b00)) begin
          w_state  = StOut;
          w_cw     = dec_result;
          w_status = dec_done;
          w_iter   = dec_iter;
        end else if (r_tmo == T_LAST) begin
          w_state  = StOut;
          w_cw     = '0;
          w_status = ST_ERR;
          w_iter   = '0;
        end
      end
      StOut: begin
        if (m_ready) begin
          w_state = StLoad;
          w_k     = '0;
        end
      end
      default: begin
        w_state = StLoad;
        w_k     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StLoad;
      r_k        <= '0;
      r_start    <= 1'b0;
      r_tmo      <= '0;
      r_max_iter <= '0;
      r_cw       <= '0;
      r_status   <= '0;
      r_iter     <= '0;
      for (int i = 0; i < int'(N); i++) begin
        r_llrs[i] <= '0;
      end
    end else begin
      r_state  <= w_state;
      r_k      <= w_k;
      r_start  <= w_start;
      r_tmo    <= w_tmo;
      r_cw     <= w_cw;
      r_status <= w_status;
      r_iter   <= w_iter;
      if (w_load_beat) begin
        r_llrs[r_k] <= w_llr;
        if (r_k == '0) begin
          r_max_iter <= cfg_max_iter;
        end
      end
    end
  end

endmodule

// File: tb/tb_llr_frame_loader.sv
// Randomized self-checking bench for llr_frame_loader against an arithmetic frame model.
module tb_llr_frame_loader;

  localparam int unsigned WIDTH       = 20;
  localparam int unsigned N           = 6;
  localparam int unsigned SAMPLE_W    = 8;
  localparam int unsigned TIMEOUT_CYC = 1024;

  logic                clk = 1'b0;
  logic                rst;
  logic                s_valid, s_ready, s_last;
  logic [SAMPLE_W-1:0] s_data;
  logic [WIDTH-1:0]    cfg_max_iter;
  logic [N*WIDTH-1:0]  dec_llrs;
  logic [WIDTH-1:0]    dec_max_iter;
  logic                dec_rst;
  logic [1:0]          dec_done;
  logic [N-1:0]        dec_result;
  logic [WIDTH-1:0]    dec_iter;
  logic                m_valid, m_ready;
  logic [N-1:0]        m_cw;
  logic [1:0]          m_status;
  logic [WIDTH-1:0]    m_iter;

  logic                s_valid2, s_ready2, s_last2;
  logic [SAMPLE_W-1:0] s_data2;
  logic [N*WIDTH-1:0]  dec_llrs2;
  logic [WIDTH-1:0]    dec_max_iter2;
  logic                dec_rst2;
  logic                m_valid2;
  logic [N-1:0]        m_cw2;
  logic [1:0]          m_status2;
  logic [WIDTH-1:0]    m_iter2;

  int n_checks = 0;
  int n_errors = 0;
  int conv_tab[N] = '{10, -3, 7, 5, -8, 2};
  int sat_tab[N]  = '{127, -127, -128, 16, 15, -16};

  always #5 clk = ~clk;

  llr_frame_loader #(
    .WIDTH(WIDTH), .N(N), .SAMPLE_W(SAMPLE_W), .LLR_SHIFT(4), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .cfg_max_iter(cfg_max_iter), .dec_llrs(dec_llrs),
    .dec_max_iter(dec_max_iter), .dec_rst(dec_rst), .dec_done(dec_done),
    .dec_result(dec_result), .dec_iter(dec_iter), .m_valid(m_valid), .m_ready(m_ready),
    .m_cw(m_cw), .m_status(m_status), .m_iter(m_iter)
  );

  llr_frame_loader #(
    .WIDTH(WIDTH), .N(N), .SAMPLE_W(SAMPLE_W), .LLR_SHIFT(15), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_dut_sat (
    .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .s_last(s_last2), .cfg_max_iter(cfg_max_iter), .dec_llrs(dec_llrs2),
    .dec_max_iter(dec_max_iter2), .dec_rst(dec_rst2), .dec_done(2'b10),
    .dec_result(dec_result), .dec_iter(dec_iter), .m_valid(m_valid2), .m_ready(1'b1),
    .m_cw(m_cw2), .m_status(m_status2), .m_iter(m_iter2)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Ideal LLR: sample times 2^shift, clamped to the symmetric WIDTH-bit range.
  function automatic longint ref_llr(input longint s, input int sh);
    longint v, lim;
    v   = s * (longint'(1) << sh);
    lim = (longint'(1) << (WIDTH - 1)) - 1;
    if (v > lim) v = lim;
    if (v < -lim) v = -lim;
    return v;
  endfunction

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_s_ready"}, s_ready, 0);
    check({pfx, "_dec_rst"}, dec_rst, 1);
    check({pfx, "_m_valid"}, m_valid, 0);
    check({pfx, "_m_cw"}, m_cw, 0);
    check({pfx, "_m_status"}, m_status, 0);
    check({pfx, "_m_iter"}, m_iter, 0);
    check({pfx, "_dec_llrs_zero"}, dec_llrs == '0, 1);
    check({pfx, "_dec_max_iter"}, dec_max_iter, 0);
  endtask

  // nb beats with s_last on the final one; lat = RUN cycle index where done appears (<0: never).
  task automatic run_frame(input int nb, input bit use_tab, input logic [1:0] code,
                           input int lat, input int hold, input int iter_v);
    longint             exp_slot[N];
    logic [WIDTH-1:0]   mi, it;
    logic [N-1:0]       res;
    logic [N*WIDTH-1:0] llr_snap;
    logic [63:0]        out_snap;
    logic [1:0]         exp_st;
    logic [N-1:0]       exp_cw;
    logic [WIDTH-1:0]   exp_it;
    bit                 good, ok_ready, rst_quiet, stable;
    int                 w, r, r_exp;
    good      = (nb == int'(N));
    ok_ready  = 1'b1;
    rst_quiet = 1'b1;
    stable    = 1'b1;
    mi        = WIDTH'($urandom);
    res       = N'($urandom);
    it        = (iter_v < 0) ? WIDTH'($urandom_range(1, 40)) : WIDTH'(iter_v);
    dec_done  = 2'b00;
    for (int b = 0; b < nb; b++) begin
      if (b > 0 && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(negedge clk);
        if (dec_rst) rst_quiet = 1'b0;
      end
      s_valid      = 1'b1;
      s_last       = (b == nb - 1);
      s_data       = use_tab ? SAMPLE_W'(conv_tab[b]) : SAMPLE_W'($urandom);
      cfg_max_iter = (b == 0) ? mi : WIDTH'($urandom);
      if (b < int'(N)) exp_slot[b] = ref_llr($signed(s_data), 4);
      w = 0;
      while (!s_ready && w < 8) begin
        @(negedge clk);
        w++;
      end
      if (!s_ready) ok_ready = 1'b0;
      if (dec_rst) rst_quiet = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("beat_accept", ok_ready, 1);
    check("no_dec_rst_in_load", rst_quiet, 1);
    if (good) begin
      check("start1_dec_rst", dec_rst, 1);
      check("start_s_ready", s_ready, 0);
      check("max_iter_latch", dec_max_iter, mi);
      for (int k = 0; k < int'(N); k++)
        check($sformatf("slot%0d", k), $signed(dec_llrs[k*WIDTH +: WIDTH]), exp_slot[k]);
      llr_snap = dec_llrs;
      @(negedge clk);
      check("start2_dec_rst", dec_rst, 1);
      @(negedge clk);
      check("run_dec_rst", dec_rst, 0);
      r = 0;
      forever begin
        if (m_valid || r > int'(TIMEOUT_CYC) + 4) break;
        if (lat >= 0 && r >= lat) begin
          dec_done   = code;
          dec_result = res;
          dec_iter   = it;
        end else begin
          dec_done   = 2'b00;
          dec_result = N'($urandom);
          dec_iter   = WIDTH'($urandom);
        end
        @(negedge clk);
        r++;
      end
      r_exp = (lat < 0) ? int'(TIMEOUT_CYC) : ((lat < 1) ? 1 : lat) + 1;
      check("out_latency", r, r_exp);
      check("llr_stable", dec_llrs == llr_snap, 1);
      exp_st = (lat < 0) ? 2'b11 : code;
      exp_cw = (lat < 0) ? '0 : res;
      exp_it = (lat < 0) ? '0 : it;
    end else begin
      check("err_m_valid", m_valid, 1);
      check("err_dec_rst", dec_rst, 0);
      exp_st = 2'b11;
      exp_cw = '0;
      exp_it = '0;
    end
    dec_done = 2'b00;
    check("m_status", m_status, exp_st);
    check("m_cw", m_cw, exp_cw);
    check("m_iter", m_iter, exp_it);
    check("out_s_ready", s_ready, 0);
    m_ready  = 1'b0;
    out_snap = {m_valid, s_ready, m_status, m_cw, m_iter};
    for (int h = 0; h < hold; h++) begin
      dec_done   = 2'($urandom);
      dec_result = N'($urandom);
      dec_iter   = WIDTH'($urandom);
      s_valid    = 1'($urandom);
      @(negedge clk);
      if ({m_valid, s_ready, m_status, m_cw, m_iter} != out_snap) stable = 1'b0;
    end
    if (hold > 0) check("hold_stable", stable, 1);
    s_valid  = 1'b0;
    dec_done = 2'b00;
    m_ready  = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("release_m_valid", m_valid, 0);
    check("release_s_ready", s_ready, 1);
  endtask

  initial begin
    rst          = 1'b1;
    s_valid      = 1'b0;
    s_last       = 1'b0;
    s_data       = '0;
    cfg_max_iter = '0;
    dec_done     = 2'b00;
    dec_result   = '0;
    dec_iter     = '0;
    m_ready      = 1'b0;
    s_valid2     = 1'b0;
    s_last2      = 1'b0;
    s_data2      = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);
    check("s_ready_after_rst", s_ready, 1);

    // Saturation on the LLR_SHIFT=15 instance.
    for (int b = 0; b < int'(N); b++) begin
      s_valid2 = 1'b1;
      s_data2  = SAMPLE_W'(sat_tab[b]);
      s_last2  = (b == int'(N) - 1);
      check($sformatf("sat_ready%0d", b), s_ready2, 1);
      @(negedge clk);
    end
    s_valid2 = 1'b0;
    s_last2  = 1'b0;
    for (int k = 0; k < int'(N); k++)
      check($sformatf("sat_slot%0d", k), $signed(dec_llrs2[k*WIDTH +: WIDTH]),
            ref_llr(sat_tab[k], 15));

    run_frame(N, 1'b1, 2'b10, 2, 3, 3);          // converged, table samples
    run_frame(3, 1'b0, 2'b10, 2, 0, -1);         // early s_last on beat 2
    run_frame(N, 1'b0, 2'b01, 5, 0, -1);         // normal after framing error
    run_frame(N + 3, 1'b0, 2'b10, 2, 0, -1);     // missing s_last, drop
    run_frame(N, 1'b0, 2'b10, -1, 0, -1);        // timeout
    run_frame(N, 1'b0, 2'b10, 0, 0, -1);         // done already high on first RUN cycle
    run_frame(N, 1'b0, 2'b01, 4, 20, -1);        // backpressure

    // Reset mid-LOAD while beat 3 is offered.
    for (int b = 0; b < 4; b++) begin
      s_valid      = 1'b1;
      s_last       = 1'b0;
      s_data       = SAMPLE_W'($urandom_range(1, 100));
      cfg_max_iter = WIDTH'($urandom_range(1, 1000));
      if (b == 3) rst = 1'b1;
      @(negedge clk);
    end
    check_reset_vals("midrst");
    rst     = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("s_ready_after_midrst", s_ready, 1);
    run_frame(N, 1'b0, 2'b10, 3, 0, -1);

    for (int f = 0; f < 10; f++) begin
      case ($urandom_range(0, 3))
        0: run_frame(N, 1'b0, 2'b10, $urandom_range(0, 6), $urandom_range(0, 3), -1);
        1: run_frame(N, 1'b0, 2'b01, $urandom_range(0, 6), $urandom_range(0, 3), -1);
        2: run_frame($urandom_range(1, N - 1), 1'b0, 2'b10, 2, $urandom_range(0, 3), -1);
        default: run_frame(N + $urandom_range(1, 4), 1'b0, 2'b10, 2, 0, -1);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
